// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: dark pattern, blink phase type, hex decoder.
package sevenseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {PH_VISIBLE = 1'b0, PH_HIDDEN = 1'b1} blink_ph_t;

  // Active-low hex decode, bit0=a .. bit6=g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0011000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_scan_display_if.sv
// Data/control bundle between the status logic (master) and the scan driver (slave).
interface sevenseg_scan_display_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] iNum;
  logic                    iLoad;
  logic [NUM_DIGITS-1:0]   iDp;
  logic [NUM_DIGITS-1:0]   iBlinkMask;
  logic [NUM_DIGITS-1:0]   iBlankMask;
  logic                    iLzb;
  logic [6:0]              oSeg;
  logic                    oDp;
  logic [NUM_DIGITS-1:0]   oAn;
  logic                    oFrame;

  modport master (output iNum, iLoad, iDp, iBlinkMask, iBlankMask, iLzb,
                  input  oSeg, oDp, oAn, oFrame);
  modport slave  (input  iNum, iLoad, iDp, iBlinkMask, iBlankMask, iLzb,
                  output oSeg, oDp, oAn, oFrame);
endinterface

// File: rtl/sevenseg_blink_timer.sv
// Shared blink phase generator; held at visible whenever no digit blinks.
module sevenseg_blink_timer
  import sevenseg_pkg::*;
#(
  parameter logic [31:0] BLINK_HALF = 32'd25_000_000
) (
  input  logic iClk,
  input  logic nRst,
  input  logic iEn,
  output logic oHidden
);
  localparam int BW = (BLINK_HALF > 32'd1) ? $clog2(BLINK_HALF) : 1;

  logic [BW-1:0] r_cnt;
  blink_ph_t     r_phase;

  // Half-period counter; phase flips each time it wraps.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_cnt   <= '0;
      r_phase <= PH_VISIBLE;
    end else if (!iEn) begin
      r_cnt   <= '0;
      r_phase <= PH_VISIBLE;
    end else if (r_cnt == BW'(BLINK_HALF - 32'd1)) begin
      r_cnt   <= '0;
      r_phase <= (r_phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign oHidden = (r_phase == PH_HIDDEN);
endmodule

// File: rtl/sevenseg_scan_display.sv
// Time-multiplexed hex display driver for a common-anode multi-digit display.
module sevenseg_scan_display
  import sevenseg_pkg::*;
#(
  parameter int          NUM_DIGITS  = 4,
  parameter logic [31:0] REFRESH_DIV = 32'd50_000,
  parameter logic [31:0] BLINK_HALF  = 32'd25_000_000
) (
  input  logic iClk,
  input  logic nRst,
  sevenseg_scan_display_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [NUM_DIGITS-1:0]   r_dpreg;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame;

  logic       w_slot_end;
  logic       w_dead;
  logic       w_hidden;
  logic [3:0] w_digit;
  logic       w_dp_sel;
  logic       w_blank_sel;
  logic       w_blink_sel;
  logic       w_hi_zero;
  logic       w_dark;

  assign w_slot_end = (r_cnt == CW'(REFRESH_DIV - 32'd1));
  assign w_dead     = (r_cnt == '0);

  sevenseg_blink_timer #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .iClk    (iClk),
    .nRst    (nRst),
    .iEn     (|bus.iBlinkMask),
    .oHidden (w_hidden)
  );

  // Snapshot of the digits and decimal points being shown.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_disp  <= '0;
      r_dpreg <= '0;
    end else if (bus.iLoad) begin
      r_disp  <= bus.iNum;
      r_dpreg <= bus.iDp;
    end
  end

  // Slot counter and digit index; slot count 0 is the dead cycle.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Pick the scanned digit and decide whether its zero is a leading one.
  always_comb begin
    w_digit     = 4'h0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    w_blink_sel = 1'b0;
    w_hi_zero   = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k == int'(r_idx)) begin
        w_digit     = r_disp[4*k +: 4];
        w_dp_sel    = r_dpreg[k];
        w_blank_sel = bus.iBlankMask[k];
        w_blink_sel = bus.iBlinkMask[k];
      end
      if (k >= int'(r_idx) && r_disp[4*k +: 4] != 4'h0) w_hi_zero = 1'b0;
    end
    w_dark = w_blank_sel
           | (bus.iLzb & (r_idx != '0) & w_hi_zero)
           | (w_blink_sel & w_hidden);
  end

  // Registered pins; segments are also held dark through the dead cycle.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_seg   <= SEG_OFF;
      r_dp    <= 1'b1;
      r_an    <= '1;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_slot_end & (r_idx == IW'(NUM_DIGITS - 1));
      r_an    <= w_dead ? '1 : ~(NUM_DIGITS'(1) << r_idx);
      r_seg   <= (w_dead | w_dark) ? SEG_OFF : hex_to_seg(w_digit);
      r_dp    <= (w_dead | w_dark) ? 1'b1 : ~w_dp_sel;
    end
  end

  assign bus.oSeg   = r_seg;
  assign bus.oDp    = r_dp;
  assign bus.oAn    = r_an;
  assign bus.oFrame = r_frame;
endmodule

// File: tb/tb_sevenseg_scan_display.sv
// Randomized bench for the scan display: 4-digit and 1-digit instances vs a timeline model.
module tb_sevenseg_scan_display;
  localparam int BH = 10;

  logic iClk = 1'b0;
  logic nRst = 1'b0;
  always #5 iClk = ~iClk;

  sevenseg_scan_display_if #(.NUM_DIGITS(4)) b4 ();
  sevenseg_scan_display_if #(.NUM_DIGITS(1)) b1 ();

  sevenseg_scan_display #(.NUM_DIGITS(4), .REFRESH_DIV(32'd4), .BLINK_HALF(32'd10)) u4 (
    .iClk(iClk), .nRst(nRst), .bus(b4));
  sevenseg_scan_display #(.NUM_DIGITS(1), .REFRESH_DIV(32'd2), .BLINK_HALF(32'd10)) u1 (
    .iClk(iClk), .nRst(nRst), .bus(b1));

  // Hex glyphs as listed g..a, active low.
  logic [6:0] tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_chk = 0;
  int n_fail = 0;

  // Model state: cycles since reset release, enabled-blink cycles, loaded snapshot.
  int p4, p1, bn4, bn1;
  bit [31:0] disp4, dpr4, disp1, dpr1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected pins after the edge that ends timeline position p.
  task automatic calc(input int nd, input int rd, input int p, input bit [31:0] disp,
                      input bit [31:0] dpr, input bit [31:0] blk, input bit [31:0] bln,
                      input bit lzb, input bit hidden,
                      output bit [7:0] an, output bit [6:0] seg, output bit dp,
                      output bit frm, output bit lit);
    int cnt, idx;
    bit [31:0] hi, ones;
    bit dark;
    cnt  = p % rd;
    idx  = (p / rd) % nd;
    ones = (32'd1 << nd) - 1;
    frm  = (idx == nd - 1) && (cnt == rd - 1);
    lit  = (cnt != 0);
    an   = lit ? 8'(ones & ~(32'd1 << idx)) : 8'(ones);
    hi   = disp >> (4 * idx);
    dark = bln[idx] || (lzb && idx != 0 && hi == 0) || (blk[idx] && hidden);
    seg  = dark ? 7'h7F : tab[hi[3:0]];
    dp   = dark ? 1'b1 : ~dpr[idx];
  endtask

  task automatic step();
    bit [7:0] an4, an1;
    bit [6:0] s4, s1;
    bit d4, d1, f4, f1, l4, l1, ld4, ld1;
    bit [31:0] num4, num1, dp4i, dp1i, bk4, bk1;
    calc(4, 4, p4, disp4, dpr4, 32'(b4.iBlinkMask), 32'(b4.iBlankMask), b4.iLzb,
         ((bn4 / BH) % 2) == 1, an4, s4, d4, f4, l4);
    calc(1, 2, p1, disp1, dpr1, 32'(b1.iBlinkMask), 32'(b1.iBlankMask), b1.iLzb,
         ((bn1 / BH) % 2) == 1, an1, s1, d1, f1, l1);
    ld4 = b4.iLoad; num4 = 32'(b4.iNum); dp4i = 32'(b4.iDp); bk4 = 32'(b4.iBlinkMask);
    ld1 = b1.iLoad; num1 = 32'(b1.iNum); dp1i = 32'(b1.iDp); bk1 = 32'(b1.iBlinkMask);
    @(posedge iClk);
    p4++; p1++;
    bn4 = (bk4 != 0) ? bn4 + 1 : 0;
    bn1 = (bk1 != 0) ? bn1 + 1 : 0;
    if (ld4) begin disp4 = num4; dpr4 = dp4i; end
    if (ld1) begin disp1 = num1; dpr1 = dp1i; end
    #1;
    chk("an4", 32'(b4.oAn), 32'(an4));
    chk("frame4", 32'(b4.oFrame), 32'(f4));
    if (l4) begin
      chk("seg4", 32'(b4.oSeg), 32'(s4));
      chk("dp4", 32'(b4.oDp), 32'(d4));
    end
    chk("an1", 32'(b1.oAn), 32'(an1));
    chk("frame1", 32'(b1.oFrame), 32'(f1));
    if (l1) begin
      chk("seg1", 32'(b1.oSeg), 32'(s1));
      chk("dp1", 32'(b1.oDp), 32'(d1));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load4(input logic [15:0] num, input logic [3:0] dp);
    b4.iNum = num; b4.iDp = dp; b4.iLoad = 1'b1;
    step();
    b4.iLoad = 1'b0;
  endtask

  task automatic model_reset();
    p4 = 0; p1 = 0; bn4 = 0; bn1 = 0;
    disp4 = 0; dpr4 = 0; disp1 = 0; dpr1 = 0;
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_seg4"}, 32'(b4.oSeg), 32'h7F);
    chk({tag, "_dp4"}, 32'(b4.oDp), 32'h1);
    chk({tag, "_an4"}, 32'(b4.oAn), 32'hF);
    chk({tag, "_frm4"}, 32'(b4.oFrame), 32'h0);
    chk({tag, "_an1"}, 32'(b1.oAn), 32'h1);
    chk({tag, "_seg1"}, 32'(b1.oSeg), 32'h7F);
  endtask

  // Async reset asserted between edges, then released away from the edge.
  task automatic mid_reset();
    nRst = 1'b0;
    #1;
    chk_dark("arst");
    @(posedge iClk);
    #1;
    chk_dark("hold");
    nRst = 1'b1;
    model_reset();
  endtask

  initial begin
    b4.iNum = '0; b4.iLoad = 0; b4.iDp = '0; b4.iBlinkMask = '0; b4.iBlankMask = '0; b4.iLzb = 0;
    b1.iNum = '0; b1.iLoad = 0; b1.iDp = '0; b1.iBlinkMask = '0; b1.iBlankMask = '0; b1.iLzb = 0;
    model_reset();
    #12;
    chk_dark("por");
    @(posedge iClk);
    #1;
    nRst = 1'b1;

    // Plain hex digits, no masks.
    load4(16'h12AF, 4'b0000);
    run(40);

    // Reset in the middle of a scan.
    run(5);
    mid_reset();
    load4(16'h12AF, 4'b1010);
    run(20);

    // Leading-zero blanking.
    b4.iLzb = 1'b1;
    load4(16'h0050, 4'b0000);
    run(16);
    load4(16'h0000, 4'b0001);
    run(16);
    for (int r = 0; r < 6; r++) begin
      logic [15:0] v;
      v = 16'($urandom);
      for (int k = 0; k < 4; k++) if ($urandom_range(1, 0) == 1) v[4*k +: 4] = 4'h0;
      load4(v, 4'($urandom));
      run(16);
    end
    b4.iLzb = 1'b0;

    // Blink on digit 1, then off mid-phase.
    load4(16'h8888, 4'b1111);
    b4.iBlinkMask = 4'b0010;
    run(45);
    b4.iBlinkMask = 4'b0000;
    run(10);

    // Blank overrides blink, DP dark too.
    b4.iBlankMask = 4'b0001; b4.iBlinkMask = 4'b0001;
    load4(16'h4321, 4'b0001);
    run(40);
    b4.iBlankMask = 4'b0000; b4.iBlinkMask = 4'b0000;

    // Free-running random traffic on both instances, loads and masks at any time.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(5, 0) == 0) begin
        b4.iNum = 16'($urandom); b4.iDp = 4'($urandom); b4.iLoad = 1'b1;
      end else b4.iLoad = 1'b0;
      if ($urandom_range(3, 0) == 0) begin
        b1.iNum = 4'($urandom); b1.iDp = 1'($urandom); b1.iLoad = 1'b1;
      end else b1.iLoad = 1'b0;
      if ($urandom_range(7, 0) == 0) begin
        b4.iBlankMask = ($urandom_range(2, 0) == 0) ? 4'($urandom) : 4'h0;
        b4.iLzb = 1'($urandom);
        b1.iBlankMask = ($urandom_range(3, 0) == 0) ? 1'b1 : 1'b0;
        b1.iLzb = 1'($urandom);
      end
      if ($urandom_range(39, 0) == 0) begin
        b4.iBlinkMask = 4'($urandom);
        b1.iBlinkMask = 1'($urandom);
      end
      if (i == 250) mid_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
